spmm_lhs_csr_encoder: RTL and testbench
=======================================

// Module: spmm_lhs_csr_encoder
// PURPOSE
//  Transmit side of the SpMM LHS interface. Accepts a dense NxN LHS matrix one row per cycle and compresses it to CSR.
//  Streams the result to SpMM as N-slot beats (lhs_ptr/lhs_col/lhs_data) under the lhs_ready_ns/lhs_start handshake.
//  Sits between the host/memory loader and SpMM; the PE decodes exactly what this block encodes.
// PARAMETERS
//  N    16  matrix dimension, PE slot count; power of 2, >=4
//  W    8   element width (data_t)
// PORTS
//  clock      in   1            clock
//  reset      in   1            asynchronous, active-high reset
//  in_valid   in   1            dense row present on in_row
//  in_ready   out  1            encoder accepts a row this cycle
//  in_row     in   data_t[N]    dense row; rows arrive in order 0..N-1
//  lhs_ready  in   1            from SpMM lhs_ready_ns
//  lhs_start  out  1            beat valid; transfers when lhs_start && lhs_ready
//  lhs_ptr    out  [2lgN][N]    lhs_ptr[r] = global element index of the LAST element of row r
//  lhs_col    out  [lgN][N]     column of each slot in the current beat
//  lhs_data   out  data_t[N]    value of each slot in the current beat
//  lhs_ws     out  1            tied 0 (ns mode only)
//  lhs_os     out  1            tied 0
//  done       out  1            one-cycle pulse after the last beat transfers
//  nnz        out  [2lgN+1]     total encoded elements (incl. padding zeros) of the current matrix
// BEHAVIOUR
//  Reset: state=ACCEPT, row_cnt=0, wr_ptr=0, beat_cnt=0. Outputs: lhs_start=0, done=0, nnz=0, lhs_ptr/col/data=0.
//    in_ready=1 from the first edge after reset deasserts.
//  States: ACCEPT -> SEND -> DONE -> ACCEPT.
//  ACCEPT: in_ready=1. On in_valid, compact the nonzeros of in_row in ascending column order.
//    The compacted elements append at wr_ptr in a flat N*N element buffer (col, data).
//    cnt = popcount(row != 0). If cnt==0, append one pad element (col 0, data 0) and set cnt=1.
//    Every row therefore owns >=1 element, and indices fit in 2lgN bits (max N*N-1).
//    ptr[row_cnt] <= wr_ptr+cnt-1; wr_ptr += cnt; row_cnt++.
//    Accepting row N-1 moves to SEND on the next edge with beat_cnt=0.
//  SEND: in_ready=0; lhs_start=1.
//    lhs_col/lhs_data[i] = buffer[beat_cnt*N+i] when that index < wr_ptr; otherwise col 0, data 0 (tail padding).
//    lhs_ptr is constant and identical on every beat. beats = ceil(wr_ptr/N), range 1..N.
//    On lhs_start && lhs_ready: beat_cnt++. If the last beat transferred, go to DONE.
//    lhs_ready low: hold beat and all outputs stable, with no limit on stall length.
//  DONE: done=1 for one cycle; lhs_start=0. Clear row_cnt, wr_ptr, beat_cnt; return to ACCEPT.
//  nnz is valid from SEND entry until the next matrix enters SEND.
//  Latency: last row accepted at edge t -> first beat offered in cycle t+1. Minimum matrix time is N + beats + 1 cycles.
//  Element buffer writes are registered; outputs in SEND are a mux of registers, with no combinational path from lhs_ready.
//  in_valid is ignored outside ACCEPT. lhs_ready is ignored outside SEND.
//  Reset mid-operation aborts the matrix: partial rows and beats are discarded. No done pulse is issued.
//  Arithmetic: wr_ptr is 2lgN+1 bits and never exceeds N*N. ptr and index math is unsigned, with no wrap.
// STRUCTURE
//  Package spmm_pkg: N, W, lgN, dbLgN, data_t, enc_state_t {ACCEPT,SEND,DONE}.
//  Sub-module spmm_row_compactor (combinational):
//    in: data_t row[N]. out: cnt, packed col[N], packed data[N].
//    Built as a prefix-sum of nonzero flags, scattering each nonzero to position = its prefix count.
//  Top holds the FSM, counters, ptr array, the N*N element buffer and the beat output mux.
// TESTING
//  Identity matrix, lhs_ready=1:
//    -> 1 beat; ptr[r]=r; col[i]=i; data[i]=1; done at cycle N+2.
//  All-zero matrix:
//    -> 1 beat; ptr[r]=r; all col=0, data=0; nnz=N.
//  All-ones dense matrix:
//    -> N beats; ptr[r]=N*r+N-1; each beat col[i]=i, data=1; nnz=N*N.
//  Row0 nonzeros {c2:3, c5:7, c9:1}, row1 empty, row2 {c0:4}, rows 3..N-1 one 1 on the diagonal:
//    -> ptr[0]=2, ptr[1]=3, ptr[2]=4, ptr[r]=r+2 for r>=3.
//    -> beat0 slots 0..4 = (2,3),(5,7),(9,1),(0,0),(0,4).
//    -> nnz=N+2; 2 beats, second beat tail zero-padded.
//  Dense matrix with lhs_ready low 3 cycles while beat 2 is offered:
//    -> beat 2 held bit-stable all 3 cycles; no skipped or duplicated beat; done after beat N-1.
//  Reset asserted during SEND beat 1:
//    -> lhs_start=0 immediately; no done pulse; in_ready=1 after release.
//    -> the next identity matrix encodes exactly as in the first scenario.

Source files
------------

// File: rtl/spmm_pkg.sv
// Shared constants and types for the SpMM LHS CSR encoder slice.
package spmm_pkg;
    localparam int N     = 16;
    localparam int W     = 8;
    localparam int lgN   = $clog2(N);
    localparam int dbLgN = 2 * lgN;

    typedef logic [W-1:0] data_t;

    typedef enum logic [1:0] {
        ACCEPT,
        SEND,
        DONE
    } enc_state_t;
endpackage

// File: rtl/spmm_row_compactor.sv
// Combinational row compactor: packs the nonzeros of a dense row to the low slots, in column order.
module spmm_row_compactor
    import spmm_pkg::*;
(
    input  data_t [N-1:0]          i_row,
    output logic  [lgN:0]          o_cnt,
    output logic  [N-1:0][lgN-1:0] o_col,
    output data_t [N-1:0]          o_data
);
    localparam int CW = lgN + 1;

    // Running prefix count of nonzeros is each element's destination slot
    logic [CW-1:0] w_acc;

    always_comb begin
        o_col  = '0;
        o_data = '0;
        w_acc  = '0;
        for (int i = 0; i < N; i++) begin
            if (|i_row[i]) begin
                o_col[w_acc[lgN-1:0]]  = lgN'(i);
                o_data[w_acc[lgN-1:0]] = i_row[i];
            end
            w_acc = w_acc + CW'(|i_row[i]);
        end
        o_cnt = w_acc;
    end
endmodule

// File: rtl/spmm_lhs_csr_encoder.sv
// Dense-to-CSR encoder for the SpMM LHS port: takes N rows, streams ceil(nnz/N) beats to SpMM.
module spmm_lhs_csr_encoder
    import spmm_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  data_t [N-1:0]             i_in_row,
    input  logic                      i_lhs_ready,
    output logic                      o_lhs_start,
    output logic  [N-1:0][dbLgN-1:0]  o_lhs_ptr,
    output logic  [N-1:0][lgN-1:0]    o_lhs_col,
    output data_t [N-1:0]             o_lhs_data,
    output logic                      o_lhs_ws,
    output logic                      o_lhs_os,
    output logic                      o_done,
    output logic  [dbLgN:0]           o_nnz
);
    enc_state_t r_state, w_next;

    logic                     r_up;
    logic [lgN-1:0]           r_row_cnt;
    logic [lgN-1:0]           r_beat_cnt;
    logic [dbLgN:0]           r_wr_ptr;
    logic [dbLgN:0]           r_nnz;
    logic [N-1:0][dbLgN-1:0]  r_ptr;
    logic [lgN-1:0]           r_buf_col  [N*N];
    data_t                    r_buf_data [N*N];

    logic [lgN:0]             w_cnt_raw, w_cnt;
    logic [N-1:0][lgN-1:0]    w_comp_col;
    data_t [N-1:0]            w_comp_data;
    logic                     w_accept, w_xfer, w_last_row, w_last_beat;
    logic [dbLgN:0]           w_wr_end, w_ptr_full, w_beat_end;
    logic [lgN:0]             w_beat_p1;
    logic [dbLgN-1:0]         w_idx;

    spmm_row_compactor u_compactor (
        .i_row  (i_in_row),
        .o_cnt  (w_cnt_raw),
        .o_col  (w_comp_col),
        .o_data (w_comp_data)
    );

    // An empty row still owns one (col 0, data 0) element so every ptr entry is distinct
    assign w_cnt       = (w_cnt_raw == '0) ? (lgN+1)'(1) : w_cnt_raw;
    assign w_wr_end    = r_wr_ptr + {{(dbLgN-lgN){1'b0}}, w_cnt};
    assign w_ptr_full  = w_wr_end - (dbLgN+1)'(1);
    assign w_accept    = (r_state == ACCEPT) && r_up && i_in_valid;
    assign w_last_row  = (r_row_cnt == lgN'(N-1));
    assign w_xfer      = (r_state == SEND) && i_lhs_ready;
    assign w_beat_p1   = {1'b0, r_beat_cnt} + (lgN+1)'(1);
    assign w_beat_end  = {w_beat_p1, {lgN{1'b0}}};
    assign w_last_beat = (w_beat_end >= r_wr_ptr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ACCEPT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCEPT:  if (w_accept && w_last_row) w_next = SEND;
            SEND:    if (w_xfer && w_last_beat)  w_next = DONE;
            DONE:    w_next = ACCEPT;
            default: w_next = ACCEPT;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == ACCEPT) && r_up;
        o_lhs_start = (r_state == SEND);
        o_done      = (r_state == DONE);
        o_lhs_ptr   = (r_state == SEND) ? r_ptr : '0;
        o_lhs_col   = '0;
        o_lhs_data  = '0;
        w_idx       = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {r_beat_cnt, lgN'(i)};
            if ((r_state == SEND) && ({1'b0, w_idx} < r_wr_ptr)) begin
                o_lhs_col[i]  = r_buf_col[w_idx];
                o_lhs_data[i] = r_buf_data[w_idx];
            end
        end
    end

    assign o_lhs_ws = 1'b0;
    assign o_lhs_os = 1'b0;
    assign o_nnz    = r_nnz;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_up       <= 1'b0;
            r_row_cnt  <= '0;
            r_beat_cnt <= '0;
            r_wr_ptr   <= '0;
            r_nnz      <= '0;
            r_ptr      <= '0;
        end else begin
            r_up <= 1'b1;
            case (r_state)
                ACCEPT: if (w_accept) begin
                    r_ptr[r_row_cnt] <= w_ptr_full[dbLgN-1:0];
                    r_wr_ptr         <= w_wr_end;
                    r_row_cnt        <= r_row_cnt + lgN'(1);
                    if (w_last_row) begin
                        r_beat_cnt <= '0;
                        r_nnz      <= w_wr_end;
                    end
                end
                SEND: if (w_xfer) r_beat_cnt <= r_beat_cnt + lgN'(1);
                DONE: begin
                    r_row_cnt  <= '0;
                    r_wr_ptr   <= '0;
                    r_beat_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Element storage needs no reset: only indices below wr_ptr are ever read
    always_ff @(posedge clock) begin
        if (w_accept) begin
            for (int k = 0; k < N; k++) begin
                if ((lgN+1)'(k) < w_cnt) begin
                    r_buf_col[r_wr_ptr[dbLgN-1:0] + dbLgN'(k)]  <= w_comp_col[k];
                    r_buf_data[r_wr_ptr[dbLgN-1:0] + dbLgN'(k)] <= w_comp_data[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_spmm_lhs_csr_encoder.sv
// Scoreboard bench for the LHS CSR encoder: directed matrices, expected beats queued at issue time.
module tb_spmm_lhs_csr_encoder;
    import spmm_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     lhs_ready = 1'b0;
    data_t [N-1:0]            in_row = '0;
    logic                     in_ready, lhs_start, lhs_ws, lhs_os, done;
    logic [N-1:0][dbLgN-1:0]  lhs_ptr;
    logic [N-1:0][lgN-1:0]    lhs_col;
    data_t [N-1:0]            lhs_data;
    logic [dbLgN:0]           nnz;

    spmm_lhs_csr_encoder dut (
        .clock       (clock),
        .reset       (reset),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_row    (in_row),
        .i_lhs_ready (lhs_ready),
        .o_lhs_start (lhs_start),
        .o_lhs_ptr   (lhs_ptr),
        .o_lhs_col   (lhs_col),
        .o_lhs_data  (lhs_data),
        .o_lhs_ws    (lhs_ws),
        .o_lhs_os    (lhs_os),
        .o_done      (done),
        .o_nnz       (nnz)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0][dbLgN-1:0] ptr;
        logic [N-1:0][lgN-1:0]   col;
        logic [N-1:0][W-1:0]     data;
        logic [dbLgN:0]          nnz;
        bit                      last;
    } beat_t;

    beat_t q[$];
    bit    exp_done = 1'b0;
    int    vectors = 0;
    int    errors = 0;
    data_t mat [N][N];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every offered beat against the queue head; pop only on transfer
    always @(negedge clock) begin
        if (reset) begin
            q.delete();
            exp_done = 1'b0;
        end else if (lhs_start) begin
            if (q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                chk("ptr",  lhs_ptr,  q[0].ptr);
                chk("col",  lhs_col,  q[0].col);
                chk("data", lhs_data, q[0].data);
                chk("nnz",  nnz,      q[0].nnz);
                if (lhs_ready) begin
                    exp_done = q[0].last;
                    void'(q.pop_front());
                end
            end
        end else if (done || exp_done) begin
            chk("done_pulse", done, exp_done);
            exp_done = 1'b0;
        end
    end

    task automatic clk_step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mat();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r][c] = '0;
    endtask

    // Identity (zero=0) or all-zero (zero=1): one beat, ptr[r]=r
    task automatic push_diag(input bit zero);
        beat_t e;
        for (int i = 0; i < N; i++) begin
            e.ptr[i]  = dbLgN'(i);
            e.col[i]  = zero ? '0 : lgN'(i);
            e.data[i] = zero ? '0 : W'(1);
        end
        e.nnz  = (dbLgN+1)'(N);
        e.last = 1'b1;
        q.push_back(e);
    endtask

    // Fully dense: beat b is row b; data is 1 (ramp=0) or b+1 (ramp=1)
    task automatic push_dense(input bit ramp);
        beat_t e;
        for (int b = 0; b < N; b++) begin
            for (int i = 0; i < N; i++) begin
                e.ptr[i]  = dbLgN'(N*i + N - 1);
                e.col[i]  = lgN'(i);
                e.data[i] = ramp ? W'(b + 1) : W'(1);
            end
            e.nnz  = (dbLgN+1)'(N*N);
            e.last = (b == N-1);
            q.push_back(e);
        end
    endtask

    task automatic push_mixed();
        beat_t e;
        int g;
        for (int b = 0; b < 2; b++) begin
            e.ptr[0] = 8'd2;
            e.ptr[1] = 8'd3;
            e.ptr[2] = 8'd4;
            for (int r = 3; r < N; r++) e.ptr[r] = dbLgN'(r + 2);
            for (int i = 0; i < N; i++) begin
                g = b*N + i;
                case (g)
                    0: begin e.col[i] = 2; e.data[i] = 3; end
                    1: begin e.col[i] = 5; e.data[i] = 7; end
                    2: begin e.col[i] = 9; e.data[i] = 1; end
                    3: begin e.col[i] = 0; e.data[i] = 0; end
                    4: begin e.col[i] = 0; e.data[i] = 4; end
                    default: begin
                        e.col[i]  = (g < N+2) ? lgN'(g - 2) : '0;
                        e.data[i] = (g < N+2) ? W'(1) : '0;
                    end
                endcase
            end
            e.nnz  = (dbLgN+1)'(N + 2);
            e.last = (b == 1);
            q.push_back(e);
        end
    endtask

    task automatic feed();
        int t = 0;
        while (!in_ready && t < 50) begin clk_step(); t++; end
        chk("in_ready_before_feed", in_ready, 1);
        for (int r = 0; r < N; r++) begin
            in_valid = 1'b1;
            for (int c = 0; c < N; c++) in_row[c] = mat[r][c];
            clk_step();
        end
        in_valid = 1'b0;
        in_row   = '0;
        chk("first_beat_latency", lhs_start, 1);
    endtask

    task automatic wait_done(input int exp_nnz);
        int t = 0;
        while (!done && t < 200) begin clk_step(); t++; end
        chk("done_seen", done, 1);
        clk_step();
        chk("nnz_hold", nnz, exp_nnz);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic wait_qsize(input int n);
        int t = 0;
        while (q.size() != n && t < 100) begin clk_step(); t++; end
        chk("beat_progress", q.size(), n);
    endtask

    initial begin
        #12;
        chk("rst_lhs_start", lhs_start, 0);
        chk("rst_done", done, 0);
        chk("rst_nnz", nnz, 0);
        chk("rst_ptr", lhs_ptr, 0);
        chk("rst_col", lhs_col, 0);
        chk("rst_data", lhs_data, 0);
        chk("rst_ws_os", {lhs_ws, lhs_os}, 0);
        clk_step();
        reset = 1'b0;
        clk_step();
        chk("in_ready_after_reset", in_ready, 1);
        lhs_ready = 1'b1;

        // identity
        clear_mat();
        for (int r = 0; r < N; r++) mat[r][r] = 8'd1;
        push_diag(1'b0);
        feed();
        wait_done(N);

        // all zero
        clear_mat();
        push_diag(1'b1);
        feed();
        wait_done(N);

        // all ones
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r][c] = 8'd1;
        push_dense(1'b0);
        feed();
        wait_done(N*N);

        // mixed sparsity with an empty row
        clear_mat();
        mat[0][2] = 8'd3;
        mat[0][5] = 8'd7;
        mat[0][9] = 8'd1;
        mat[2][0] = 8'd4;
        for (int r = 3; r < N; r++) mat[r][r] = 8'd1;
        push_mixed();
        feed();
        wait_done(N + 2);

        // dense ramp with a 3-cycle stall on beat 2
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r][c] = W'(r + 1);
        push_dense(1'b1);
        feed();
        wait_qsize(N - 2);
        lhs_ready = 1'b0;
        repeat (3) clk_step();
        lhs_ready = 1'b1;
        wait_done(N*N);

        // reset while beat 1 is offered
        push_dense(1'b1);
        feed();
        wait_qsize(N - 1);
        reset = 1'b1;
        #1;
        chk("abort_lhs_start", lhs_start, 0);
        chk("abort_done", done, 0);
        clk_step();
        clk_step();
        reset = 1'b0;
        clk_step();
        chk("in_ready_after_abort", in_ready, 1);

        // identity again after the abort
        clear_mat();
        for (int r = 0; r < N; r++) mat[r][r] = 8'd1;
        push_diag(1'b0);
        feed();
        wait_done(N);

        repeat (3) clk_step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
